// File: rtl/data_path_pkg.sv
`default_nettype none
// ============================================================================
// Package  : datapath_pkg
// Desc     : Shared width constant and bus-select / ALU-op encodings.
// Revision : 1.0
// ============================================================================
package datapath_pkg;

    localparam int DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        SEL_NONE = 3'd0,
        SEL_MDR  = 3'd1,
        SEL_ZLO  = 3'd2,
        SEL_R2   = 3'd3,
        SEL_R3   = 3'd4,
        SEL_PC   = 3'd5
    } bus_sel_e;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_AND  = 2'd1,
        OP_OR   = 2'd2,
        OP_INC  = 2'd3
    } alu_op_e;

endpackage
`default_nettype wire

// File: rtl/data_path_if.sv
`default_nettype none
// ============================================================================
// Interface : data_path_if
// Desc      : Control strobes, memory data and register observation bus.
//             The OR strobe exists only when DATAPATH_OR_OP_EN is defined.
// Revision  : 1.0
// ============================================================================
interface data_path_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] Mdatain;
    logic                  Read;
    logic                  MDRin, IRin, Yin, R1in, R2in, R3in;
    logic                  PCout, Zlowout, MDRout, R2out, R3out;
    logic                  AND;
`ifdef DATAPATH_OR_OP_EN
    logic                  OR;
`endif
    logic [DATA_WIDTH-1:0] BusMuxOut;
    logic [DATA_WIDTH-1:0] PC_q, IR_q, MDR_q, Y_q, R1_q, R2_q, R3_q;
    logic [DATA_WIDTH-1:0] Zlow_q, Zhigh_q;

    modport master (
`ifdef DATAPATH_OR_OP_EN
        output OR,
`endif
        output Mdatain, Read,
        output MDRin, IRin, Yin, R1in, R2in, R3in,
        output PCout, Zlowout, MDRout, R2out, R3out, AND,
        input  BusMuxOut, PC_q, IR_q, MDR_q, Y_q, R1_q, R2_q, R3_q,
        input  Zlow_q, Zhigh_q
    );

    modport slave (
`ifdef DATAPATH_OR_OP_EN
        input  OR,
`endif
        input  Mdatain, Read,
        input  MDRin, IRin, Yin, R1in, R2in, R3in,
        input  PCout, Zlowout, MDRout, R2out, R3out, AND,
        output BusMuxOut, PC_q, IR_q, MDR_q, Y_q, R1_q, R2_q, R3_q,
        output Zlow_q, Zhigh_q
    );

endinterface
`default_nettype wire

// File: rtl/data_path_dp_reg.sv
`default_nettype none
// ============================================================================
// Module   : dp_reg
// Desc     : Width-parameterised register with load enable, async active-low
//            clear and configurable reset value.
// Revision : 1.0
// ============================================================================
module dp_reg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_en,
    input  wire logic [WIDTH-1:0] i_d,
    output logic      [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= RESET_VAL;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/data_path.sv
`default_nettype none
// ============================================================================
// Module   : data_path
// Desc     : Single-bus CPU datapath (PC, IR, MDR, Y, Z, R1-R3, bus mux, ALU).
//            Optional OR operation enabled by DATAPATH_OR_OP_EN.
// Revision : 1.0
// ============================================================================
module data_path
    import datapath_pkg::*;
#(
    parameter int                    DATA_WIDTH = datapath_pkg::DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] PC_RESET   = '0
) (
    input  wire logic  clock,
    input  wire logic  clear,
    data_path_if.slave dp
);

    bus_sel_e              w_sel;
    alu_op_e               w_op;
    logic [DATA_WIDTH-1:0] w_bus;
    logic [DATA_WIDTH-1:0] w_alu;
    logic                  w_z_en;
    logic [DATA_WIDTH-1:0] w_mdr_d;
    logic [DATA_WIDTH-1:0] w_pc, w_ir, w_mdr, w_y, w_r1, w_r2, w_r3, w_zlo, w_zhi;

    // Fixed priority resolves overlapping selects; one-hot use never notices.
    always_comb begin
        w_sel = SEL_NONE;
        if (dp.MDRout) begin
            w_sel = SEL_MDR;
        end else if (dp.Zlowout) begin
            w_sel = SEL_ZLO;
        end else if (dp.R2out) begin
            w_sel = SEL_R2;
        end else if (dp.R3out) begin
            w_sel = SEL_R3;
        end else if (dp.PCout) begin
            w_sel = SEL_PC;
        end
    end

    always_comb begin
        w_bus = '0;
        case (w_sel)
            SEL_MDR: w_bus = w_mdr;
            SEL_ZLO: w_bus = w_zlo;
            SEL_R2:  w_bus = w_r2;
            SEL_R3:  w_bus = w_r3;
            SEL_PC:  w_bus = w_pc;
            default: w_bus = '0;
        endcase
    end

    // PCout doubles as the increment request when no logic op is strobed.
    always_comb begin
        w_op = OP_NONE;
        if (dp.AND) begin
            w_op = OP_AND;
        end
`ifdef DATAPATH_OR_OP_EN
        else if (dp.OR) begin
            w_op = OP_OR;
        end
`endif
        else if (dp.PCout) begin
            w_op = OP_INC;
        end
    end

    always_comb begin
        w_alu = '0;
        case (w_op)
            OP_AND:  w_alu = w_y & w_bus;
            OP_OR:   w_alu = w_y | w_bus;
            OP_INC:  w_alu = w_bus + DATA_WIDTH'(1);
            default: w_alu = '0;
        endcase
    end

    assign w_z_en  = (w_op != OP_NONE);
    assign w_mdr_d = dp.Read ? dp.Mdatain : w_bus;

    dp_reg #(.WIDTH(DATA_WIDTH), .RESET_VAL(PC_RESET)) u_pc (
        .clk(clock), .rst_n(clear), .i_en(1'b0), .i_d(w_pc), .o_q(w_pc)
    );
    dp_reg #(.WIDTH(DATA_WIDTH)) u_ir (
        .clk(clock), .rst_n(clear), .i_en(dp.IRin), .i_d(w_bus), .o_q(w_ir)
    );
    dp_reg #(.WIDTH(DATA_WIDTH)) u_mdr (
        .clk(clock), .rst_n(clear), .i_en(dp.MDRin), .i_d(w_mdr_d), .o_q(w_mdr)
    );
    dp_reg #(.WIDTH(DATA_WIDTH)) u_y (
        .clk(clock), .rst_n(clear), .i_en(dp.Yin), .i_d(w_bus), .o_q(w_y)
    );
    dp_reg #(.WIDTH(DATA_WIDTH)) u_r1 (
        .clk(clock), .rst_n(clear), .i_en(dp.R1in), .i_d(w_bus), .o_q(w_r1)
    );
    dp_reg #(.WIDTH(DATA_WIDTH)) u_r2 (
        .clk(clock), .rst_n(clear), .i_en(dp.R2in), .i_d(w_bus), .o_q(w_r2)
    );
    dp_reg #(.WIDTH(DATA_WIDTH)) u_r3 (
        .clk(clock), .rst_n(clear), .i_en(dp.R3in), .i_d(w_bus), .o_q(w_r3)
    );
    dp_reg #(.WIDTH(DATA_WIDTH)) u_zlo (
        .clk(clock), .rst_n(clear), .i_en(w_z_en), .i_d(w_alu), .o_q(w_zlo)
    );
    dp_reg #(.WIDTH(DATA_WIDTH)) u_zhi (
        .clk(clock), .rst_n(clear), .i_en(w_z_en), .i_d({DATA_WIDTH{1'b0}}), .o_q(w_zhi)
    );

    assign dp.BusMuxOut = w_bus;
    assign dp.PC_q      = w_pc;
    assign dp.IR_q      = w_ir;
    assign dp.MDR_q     = w_mdr;
    assign dp.Y_q       = w_y;
    assign dp.R1_q      = w_r1;
    assign dp.R2_q      = w_r2;
    assign dp.R3_q      = w_r3;
    assign dp.Zlow_q    = w_zlo;
    assign dp.Zhigh_q   = w_zhi;

endmodule
`default_nettype wire

// File: tb/tb_data_path.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_path
// Desc     : Scoreboard bench for data_path: stimulus queues expected values,
//            a negedge monitor pops and compares them.
// Revision : 1.0
// ============================================================================
module tb_data_path;
    import datapath_pkg::*;

    typedef enum int {
        F_BUS, F_PC, F_IR, F_MDR, F_Y, F_R1, F_R2, F_R3, F_ZLO, F_ZHI,
        F_W_PC, F_W_BUS, F_W_ZLO, F_W_ZHI
    } field_e;

    typedef struct {
        field_e      f;
        logic [31:0] v;
        string       nm;
    } exp_t;

    logic clock = 1'b0;
    logic clear = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    exp_t sbq[$];

    always #5 clock = ~clock;

    data_path_if #(.DATA_WIDTH(32)) dif  ();
    data_path_if #(.DATA_WIDTH(32)) dif2 ();

    data_path #(.DATA_WIDTH(32), .PC_RESET(32'h0000_0000)) dut (
        .clock(clock), .clear(clear), .dp(dif)
    );
    // Second instance exercises the increment wrap from an all-ones PC.
    data_path #(.DATA_WIDTH(32), .PC_RESET(32'hFFFF_FFFF)) dut_w (
        .clock(clock), .clear(clear), .dp(dif2)
    );

    function automatic logic [31:0] probe(field_e f);
        case (f)
            F_BUS:   return dif.BusMuxOut;
            F_PC:    return dif.PC_q;
            F_IR:    return dif.IR_q;
            F_MDR:   return dif.MDR_q;
            F_Y:     return dif.Y_q;
            F_R1:    return dif.R1_q;
            F_R2:    return dif.R2_q;
            F_R3:    return dif.R3_q;
            F_ZLO:   return dif.Zlow_q;
            F_ZHI:   return dif.Zhigh_q;
            F_W_PC:  return dif2.PC_q;
            F_W_BUS: return dif2.BusMuxOut;
            F_W_ZLO: return dif2.Zlow_q;
            F_W_ZHI: return dif2.Zhigh_q;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic expect_val(input field_e f, input logic [31:0] v, input string nm);
        exp_t e;
        e.f  = f;
        e.v  = v;
        e.nm = nm;
        sbq.push_back(e);
    endtask

    task automatic expect_all_zero(input string nm);
        expect_val(F_BUS, 32'h0, {nm, "_bus"});
        expect_val(F_PC,  32'h0, {nm, "_pc"});
        expect_val(F_IR,  32'h0, {nm, "_ir"});
        expect_val(F_MDR, 32'h0, {nm, "_mdr"});
        expect_val(F_Y,   32'h0, {nm, "_y"});
        expect_val(F_R1,  32'h0, {nm, "_r1"});
        expect_val(F_R2,  32'h0, {nm, "_r2"});
        expect_val(F_R3,  32'h0, {nm, "_r3"});
        expect_val(F_ZLO, 32'h0, {nm, "_zlo"});
        expect_val(F_ZHI, 32'h0, {nm, "_zhi"});
    endtask

    initial begin
        exp_t e;
        logic [31:0] act;
        forever begin
            @(negedge clock);
            while (sbq.size() > 0) begin
                e   = sbq.pop_front();
                act = probe(e.f);
                checks++;
                if (act !== e.v) begin
                    failures++;
                    $display("FAIL %s: actual=%08h expected=%08h", e.nm, act, e.v);
                end
            end
        end
    end

    task automatic idle();
        dif.Mdatain = '0;  dif.Read = 0;
        dif.MDRin = 0; dif.IRin = 0; dif.Yin = 0; dif.R1in = 0; dif.R2in = 0; dif.R3in = 0;
        dif.PCout = 0; dif.Zlowout = 0; dif.MDRout = 0; dif.R2out = 0; dif.R3out = 0;
        dif.AND = 0;
        dif2.Mdatain = '0; dif2.Read = 0;
        dif2.MDRin = 0; dif2.IRin = 0; dif2.Yin = 0; dif2.R1in = 0; dif2.R2in = 0; dif2.R3in = 0;
        dif2.PCout = 0; dif2.Zlowout = 0; dif2.MDRout = 0; dif2.R2out = 0; dif2.R3out = 0;
        dif2.AND = 0;
`ifdef DATAPATH_OR_OP_EN
        dif.OR = 0;
        dif2.OR = 0;
`endif
    endtask

    // Advance one edge; inputs for the next cycle are applied 1 unit later.
    task automatic cyc();
        @(posedge clock);
        #1;
        idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        clear = 1'b0;
        @(posedge clock); #1;
        expect_all_zero("reset");
        expect_val(F_W_PC, 32'hFFFF_FFFF, "reset_pc_w");
        cyc();
        clear = 1'b1;
        cyc();
        expect_all_zero("hold");

        // Register loads through MDR
        dif.Mdatain = 32'h12; dif.Read = 1; dif.MDRin = 1;
        cyc();
        expect_val(F_MDR, 32'h12, "mdr_load");
        dif.Mdatain = 32'h11; dif.MDRout = 1; dif.R2in = 1;
        expect_val(F_BUS, 32'h12, "bus_mdr");
        cyc();
        expect_val(F_R2,  32'h12, "r2_load");
        expect_val(F_MDR, 32'h12, "mdr_unchanged");
        dif.Mdatain = 32'h14; dif.Read = 1; dif.MDRin = 1;
        cyc();
        dif.Mdatain = 32'h11; dif.MDRout = 1; dif.R3in = 1;
        cyc();
        expect_val(F_R3, 32'h14, "r3_load");
        dif.Mdatain = 32'h18; dif.Read = 1; dif.MDRin = 1;
        cyc();
        dif.Mdatain = 32'h11; dif.MDRout = 1; dif.R1in = 1;
        cyc();
        expect_val(F_R1, 32'h18, "r1_load");

        // Fetch
        dif.PCout = 1;
        expect_val(F_BUS, 32'h0, "bus_pc");
        dif2.PCout = 1;
        expect_val(F_W_BUS, 32'hFFFF_FFFF, "bus_pc_w");
        cyc();
        expect_val(F_ZLO, 32'h1, "fetch_zlo");
        expect_val(F_ZHI, 32'h0, "fetch_zhi");
        expect_val(F_W_ZLO, 32'h0, "wrap_zlo");
        expect_val(F_W_ZHI, 32'h0, "wrap_zhi");
        dif.Zlowout = 1; dif.Read = 1; dif.MDRin = 1; dif.Mdatain = 32'h3;
        expect_val(F_BUS, 32'h1, "fetch_bus_zlo");
        cyc();
        expect_val(F_MDR, 32'h3, "fetch_mdr");
        dif.MDRout = 1; dif.IRin = 1;
        cyc();
        expect_val(F_IR, 32'h3, "fetch_ir");

        // AND R1, R2, R3
        dif.R2out = 1; dif.Yin = 1;
        cyc();
        expect_val(F_Y, 32'h12, "and_y");
        dif.R3out = 1; dif.AND = 1;
        expect_val(F_BUS, 32'h14, "and_bus_r3");
        cyc();
        expect_val(F_ZLO, 32'h10, "and_zlo");
        expect_val(F_ZHI, 32'h0,  "and_zhi");
        dif.Zlowout = 1; dif.R1in = 1;
        cyc();
        expect_val(F_R1, 32'h10, "and_r1");

        // Bus priority
        dif.MDRout = 1; dif.R2out = 1;
        expect_val(F_BUS, 32'h3, "prio_mdr_r2");
        cyc();
        dif.Zlowout = 1; dif.R3out = 1;
        expect_val(F_BUS, 32'h10, "prio_zlo_r3");
        cyc();
        dif.R2out = 1; dif.PCout = 1;
        expect_val(F_BUS, 32'h12, "prio_r2_pc");
        cyc();
        expect_val(F_ZLO, 32'h13, "inc_from_r2");
        // AND outranks increment: Y=0x12 & R3=0x14 -> 0x10, not 0x15
        dif.R3out = 1; dif.PCout = 1; dif.AND = 1;
        cyc();
        expect_val(F_ZLO, 32'h10, "and_over_inc");
        // Z drives the bus while reloading: old value seen now, new next cycle
        dif.Zlowout = 1; dif.PCout = 1;
        expect_val(F_BUS, 32'h10, "zlo_old_on_bus");
        cyc();
        expect_val(F_ZLO, 32'h11, "zlo_new");
        dif.Zlowout = 1;
        expect_val(F_BUS, 32'h11, "zlo_new_on_bus");
        cyc();

        // Async reset in the middle of an AND sequence
        dif.R2out = 1; dif.Yin = 1;
        cyc();
        dif.R3out = 1; dif.AND = 1;
        #1;
        clear = 1'b0;
        expect_all_zero("async");
        expect_val(F_W_PC, 32'hFFFF_FFFF, "async_pc_w");
        @(posedge clock); #1;
        idle();
        clear = 1'b1;
        cyc();
        expect_val(F_ZLO, 32'h0, "post_reset_zlo");
        expect_val(F_Y,   32'h0, "post_reset_y");

        cyc();
        cyc();
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: actual=%0d required=0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
